// File: rtl/simd_exc_pkg.sv
// Shared definitions for the SIMD exception path: flag bit positions,
// the flag-vector type and the trap FSM state type.
package simd_exc_pkg;

  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  typedef logic [4:0] flags_t;

  typedef enum logic {
    IDLE,
    PENDING
  } trap_state_e;

endpackage

// File: rtl/simd_fflags_unit_if.sv
// Exception bus from the lane datapath's packing stage: a retire strobe,
// the active-lane mask and five packed per-lane flag vectors.
interface simd_fflags_unit_if #(
  parameter int unsigned LANES = 4
);
  logic             ex_valid;
  logic [LANES-1:0] lane_mask;
  logic [LANES-1:0] invalid;
  logic [LANES-1:0] div_by_zero;
  logic [LANES-1:0] overflow;
  logic [LANES-1:0] underflow;
  logic [LANES-1:0] inexact;

  modport master (
    output ex_valid, lane_mask, invalid, div_by_zero, overflow, underflow, inexact
  );

  modport slave (
    input ex_valid, lane_mask, invalid, div_by_zero, overflow, underflow, inexact
  );
endinterface

// File: rtl/exc_lane_prio.sv
// Combinational lowest-set-bit encoder over the lane vector.
module exc_lane_prio #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = $clog2(LANES)
) (
  input  logic [LANES-1:0]  req,
  output logic [LANE_W-1:0] idx,
  output logic              found
);
  always_comb begin
    idx   = '0;
    found = 1'b0;
    // Scan from the top down so the lowest set bit is written last.
    for (int unsigned i = LANES; i > 0; i--) begin
      if (req[i-1]) begin
        idx   = LANE_W'(i - 1);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/simd_fflags_unit.sv
// Sticky fflags accumulation, trap capture FSM and saturating exception
// counter fed by the masked per-lane exception vectors.
module simd_fflags_unit
  import simd_exc_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = $clog2(LANES),
  parameter int unsigned CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  simd_fflags_unit_if.slave  ex,
  input  logic               csr_wr_en,
  input  flags_t             csr_wr_data,
  input  flags_t             trap_en,
  input  logic               trap_ack,
  input  logic               cnt_clr,
  output flags_t             csr_rd_data,
  output logic               trap_req,
  output flags_t             trap_cause,
  output logic [LANE_W-1:0]  trap_lane,
  output logic               trap_lost,
  output logic [CNT_W-1:0]   exc_count
);
  flags_t            new_flags;
  flags_t            en_evt;
  logic [LANES-1:0]  lane_hit;
  logic [LANE_W-1:0] hit_idx;
  logic              hit_found;

  trap_state_e       state_q, state_d;
  flags_t            fflags_q, fflags_d;
  flags_t            cause_q, cause_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              lost_q, lost_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    new_flags          = '0;
    new_flags[FLAG_NV] = ex.ex_valid & (|(ex.invalid     & ex.lane_mask));
    new_flags[FLAG_DZ] = ex.ex_valid & (|(ex.div_by_zero & ex.lane_mask));
    new_flags[FLAG_OF] = ex.ex_valid & (|(ex.overflow    & ex.lane_mask));
    new_flags[FLAG_UF] = ex.ex_valid & (|(ex.underflow   & ex.lane_mask));
    new_flags[FLAG_NX] = ex.ex_valid & (|(ex.inexact     & ex.lane_mask));
    en_evt             = new_flags & trap_en;
    // Lanes that are active and raise at least one of the flags being captured.
    lane_hit = ex.lane_mask & (({LANES{en_evt[FLAG_NV]}} & ex.invalid)
                             | ({LANES{en_evt[FLAG_DZ]}} & ex.div_by_zero)
                             | ({LANES{en_evt[FLAG_OF]}} & ex.overflow)
                             | ({LANES{en_evt[FLAG_UF]}} & ex.underflow)
                             | ({LANES{en_evt[FLAG_NX]}} & ex.inexact));
  end

  exc_lane_prio #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_prio (
    .req   (lane_hit),
    .idx   (hit_idx),
    .found (hit_found)
  );

  always_comb begin
    fflags_d = csr_wr_en ? (csr_wr_data | new_flags) : (fflags_q | new_flags);

    state_d = state_q;
    cause_d = cause_q;
    lane_d  = lane_q;
    lost_d  = lost_q;
    unique case (state_q)
      IDLE: begin
        if (|en_evt) begin
          state_d = PENDING;
          cause_d = en_evt;
          lane_d  = hit_found ? hit_idx : '0;
        end
      end
      PENDING: begin
        if (trap_ack && (|en_evt)) begin
          cause_d = en_evt;
          lane_d  = hit_found ? hit_idx : '0;
          lost_d  = 1'b0;
        end else if (trap_ack) begin
          state_d = IDLE;
          cause_d = '0;
          lane_d  = '0;
          lost_d  = 1'b0;
        end else if (|en_evt) begin
          lost_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if ((|new_flags) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      fflags_q <= '0;
      cause_q  <= '0;
      lane_q   <= '0;
      lost_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      fflags_q <= fflags_d;
      cause_q  <= cause_d;
      lane_q   <= lane_d;
      lost_q   <= lost_d;
      cnt_q    <= cnt_d;
    end
  end

  assign csr_rd_data = fflags_q;
  assign trap_req    = (state_q == PENDING);
  assign trap_cause  = cause_q;
  assign trap_lane   = lane_q;
  assign trap_lost   = lost_q;
  assign exc_count   = cnt_q;
endmodule

// File: tb/tb_simd_fflags_unit.sv
// Directed vector bench for simd_fflags_unit: a stateful table of one-cycle
// vectors followed by counter saturation, clear priority and async reset.
module tb_simd_fflags_unit;
  logic       clk;
  logic       rst;
  logic       csr_wr_en;
  logic [4:0] csr_wr_data;
  logic [4:0] trap_en;
  logic       trap_ack;
  logic       cnt_clr;
  logic [4:0] csr_rd_data;
  logic       trap_req;
  logic [4:0] trap_cause;
  logic [1:0] trap_lane;
  logic       trap_lost;
  logic [7:0] exc_count;

  int total;
  int bad;

  simd_fflags_unit_if #(.LANES(4)) ex_if ();

  simd_fflags_unit #(
    .LANES  (4),
    .LANE_W (2),
    .CNT_W  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ex          (ex_if.slave),
    .csr_wr_en   (csr_wr_en),
    .csr_wr_data (csr_wr_data),
    .trap_en     (trap_en),
    .trap_ack    (trap_ack),
    .cnt_clr     (cnt_clr),
    .csr_rd_data (csr_rd_data),
    .trap_req    (trap_req),
    .trap_cause  (trap_cause),
    .trap_lane   (trap_lane),
    .trap_lost   (trap_lost),
    .exc_count   (exc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ev;
    logic [3:0] mask;
    logic [3:0] nv;
    logic [3:0] dz;
    logic [3:0] of;
    logic [3:0] uf;
    logic [3:0] nx;
    logic       wr;
    logic [4:0] wdata;
    logic [4:0] ten;
    logic       ack;
    logic       clr;
    logic [4:0] e_rd;
    logic       e_req;
    logic [4:0] e_cause;
    logic [1:0] e_lane;
    logic       e_lost;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic [3:0] mask, input logic [3:0] nv,
                       input logic [3:0] dz, input logic [3:0] of, input logic [3:0] uf,
                       input logic [3:0] nx, input logic wr, input logic [4:0] wdata,
                       input logic [4:0] ten, input logic ack, input logic clr);
    ex_if.ex_valid    = ev;
    ex_if.lane_mask   = mask;
    ex_if.invalid     = nv;
    ex_if.div_by_zero = dz;
    ex_if.overflow    = of;
    ex_if.underflow   = uf;
    ex_if.inexact     = nx;
    csr_wr_en         = wr;
    csr_wr_data       = wdata;
    trap_en           = ten;
    trap_ack          = ack;
    cnt_clr           = clr;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 5'h00, 5'h00, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle_inputs();

    //        ev    mask   nv     dz     of     uf     nx     wr    wdata     ten       ack   clr   e_rd      req   cause     lane  lost  cnt
    vecs[0]  = '{1'b1, 4'b0101, 4'h0, 4'h0, 4'b1010, 4'h0, 4'b0100, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 5'b00001, 1'b0, 5'b00000, 2'd0, 1'b0, 8'd1};
    vecs[1]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 5'b00000, 5'b00000, 1'b0, 1'b0, 5'b00000, 1'b0, 5'b00000, 2'd0, 1'b0, 8'd1};
    vecs[2]  = '{1'b1, 4'b1111, 4'b1100, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 5'b00000, 5'b10000, 1'b0, 1'b0, 5'b10000, 1'b1, 5'b10000, 2'd2, 1'b0, 8'd2};
    vecs[3]  = '{1'b1, 4'b1111, 4'h0, 4'b0001, 4'h0, 4'h0, 4'h0, 1'b0, 5'b00000, 5'b11000, 1'b0, 1'b0, 5'b11000, 1'b1, 5'b10000, 2'd2, 1'b1, 8'd3};
    vecs[4]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 5'b00000, 5'b00000, 1'b1, 1'b0, 5'b11000, 1'b0, 5'b00000, 2'd0, 1'b0, 8'd3};
    vecs[5]  = '{1'b1, 4'b1111, 4'h0, 4'h0, 4'b0010, 4'h0, 4'h0, 1'b0, 5'b00000, 5'b00100, 1'b1, 1'b0, 5'b11100, 1'b1, 5'b00100, 2'd1, 1'b0, 8'd4};
    vecs[6]  = '{1'b1, 4'b1111, 4'h0, 4'h0, 4'b0001, 4'h0, 4'h0, 1'b0, 5'b00000, 5'b00100, 1'b0, 1'b0, 5'b11100, 1'b1, 5'b00100, 2'd1, 1'b1, 8'd5};
    vecs[7]  = '{1'b1, 4'b1111, 4'h0, 4'h0, 4'b1000, 4'h0, 4'h0, 1'b0, 5'b00000, 5'b00100, 1'b1, 1'b0, 5'b11100, 1'b1, 5'b00100, 2'd3, 1'b0, 8'd6};
    vecs[8]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 5'b00000, 5'b00000, 1'b1, 1'b0, 5'b11100, 1'b0, 5'b00000, 2'd0, 1'b0, 8'd6};
    vecs[9]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 5'b11111, 5'b00000, 1'b0, 1'b0, 5'b11111, 1'b0, 5'b00000, 2'd0, 1'b0, 8'd6};
    vecs[10] = '{1'b1, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0010, 1'b1, 5'b00000, 5'b00000, 1'b0, 1'b0, 5'b00001, 1'b0, 5'b00000, 2'd0, 1'b0, 8'd7};
    vecs[11] = '{1'b1, 4'b0001, 4'b1110, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 5'b00000, 5'b10000, 1'b0, 1'b0, 5'b00001, 1'b0, 5'b00000, 2'd0, 1'b0, 8'd7};
    vecs[12] = '{1'b0, 4'b1111, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 5'b00000, 5'b11111, 1'b0, 1'b0, 5'b00001, 1'b0, 5'b00000, 2'd0, 1'b0, 8'd7};
    vecs[13] = '{1'b1, 4'b1100, 4'b0001, 4'b0100, 4'h0, 4'b1000, 4'h0, 1'b0, 5'b00000, 5'b11111, 1'b0, 1'b0, 5'b01011, 1'b1, 5'b01010, 2'd2, 1'b0, 8'd8};
    vecs[14] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 5'b01011, 1'b1, 5'b01010, 2'd2, 1'b0, 8'd8};
    vecs[15] = '{1'b1, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0001, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b1, 5'b01011, 1'b1, 5'b01010, 2'd2, 1'b0, 8'd0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_rd",    32'(csr_rd_data), 32'd0);
    chk("reset_req",   32'(trap_req),    32'd0);
    chk("reset_cause", 32'(trap_cause),  32'd0);
    chk("reset_lane",  32'(trap_lane),   32'd0);
    chk("reset_lost",  32'(trap_lost),   32'd0);
    chk("reset_cnt",   32'(exc_count),   32'd0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i].ev, vecs[i].mask, vecs[i].nv, vecs[i].dz, vecs[i].of, vecs[i].uf,
            vecs[i].nx, vecs[i].wr, vecs[i].wdata, vecs[i].ten, vecs[i].ack, vecs[i].clr);
      step();
      chk($sformatf("v%0d_rd", i),    32'(csr_rd_data), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d_req", i),   32'(trap_req),    32'(vecs[i].e_req));
      chk($sformatf("v%0d_cause", i), 32'(trap_cause),  32'(vecs[i].e_cause));
      chk($sformatf("v%0d_lane", i),  32'(trap_lane),   32'(vecs[i].e_lane));
      chk($sformatf("v%0d_lost", i),  32'(trap_lost),   32'(vecs[i].e_lost));
      chk($sformatf("v%0d_cnt", i),   32'(exc_count),   32'(vecs[i].e_cnt));
    end

    // Leave the pending trap, then drive 300 flagged ops into a zero counter.
    @(negedge clk);
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 5'h00, 5'h00, 1'b1, 1'b0);
    step();
    chk("ack_req", 32'(trap_req), 32'd0);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      drive(1'b1, 4'b0001, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0001, 1'b0, 5'h00, 5'h00, 1'b0, 1'b0);
      step();
      if (n == 254) chk("cnt_at_255", 32'(exc_count), 32'd255);
    end
    chk("cnt_saturated", 32'(exc_count), 32'd255);
    chk("sat_no_trap",   32'(trap_req),  32'd0);

    @(negedge clk);
    drive(1'b1, 4'b0001, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0001, 1'b0, 5'h00, 5'h00, 1'b0, 1'b1);
    step();
    chk("clr_priority", 32'(exc_count), 32'd0);

    // Enter PENDING, then pulse reset between clock edges.
    @(negedge clk);
    drive(1'b1, 4'b1111, 4'h0, 4'b0100, 4'h0, 4'h0, 4'h0, 1'b0, 5'h00, 5'b01000, 1'b0, 1'b0);
    step();
    chk("pre_rst_req",   32'(trap_req),   32'd1);
    chk("pre_rst_cause", 32'(trap_cause), 32'b01000);
    chk("pre_rst_lane",  32'(trap_lane),  32'd2);
    chk("pre_rst_cnt",   32'(exc_count),  32'd1);
    @(negedge clk);
    idle_inputs();
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_req",   32'(trap_req),    32'd0);
    chk("async_rst_cause", 32'(trap_cause),  32'd0);
    chk("async_rst_lane",  32'(trap_lane),   32'd0);
    chk("async_rst_rd",    32'(csr_rd_data), 32'd0);
    chk("async_rst_cnt",   32'(exc_count),   32'd0);
    chk("async_rst_lost",  32'(trap_lost),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_req", 32'(trap_req), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
